// File: rtl/spdif_pkg.sv
// Shared SPDIF definitions: preamble codes, block length, subframe field positions
// and the frame sequencer state encoding.
package spdif_pkg;

  typedef logic [1:0] preamble_t;

  localparam preamble_t PREAMBLE_B = 2'd0;
  localparam preamble_t PREAMBLE_M = 2'd1;
  localparam preamble_t PREAMBLE_W = 2'd2;

  localparam int         FRAMES_PER_BLOCK = 192;
  localparam logic [7:0] LAST_FRAME       = 8'(FRAMES_PER_BLOCK - 1);

  localparam int SF_AUDIO_MSB = 27;
  localparam int SF_V_BIT     = 28;
  localparam int SF_U_BIT     = 29;
  localparam int SF_C_BIT     = 30;
  localparam int SF_P_BIT     = 31;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LEFT,
    ST_RIGHT
  } seq_state_t;

  // Even-parity bit over the time slots 4..30 of a subframe.
  function automatic logic even_parity(input logic [26:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/spdif_subframe_pack.sv
// Combinational IEC-60958 subframe builder: left-justified audio, V/U/C flags and
// the closing parity bit. Preamble slot (bits 3:0) is left at zero.
module spdif_subframe_pack
  import spdif_pkg::*;
#(
  parameter int SAMPLE_W = 24
) (
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                v,
  input  logic                u,
  input  logic                c,
  output logic [31:0]         subframe
);

  logic [SF_C_BIT:0] body;

  // Assemble all fields below the parity bit, then append even parity over 4..30.
  // NOTE: every variable driven from always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    body                                = '0;
    body[SF_AUDIO_MSB -: SAMPLE_W]      = sample;
    body[SF_V_BIT]                      = v;
    body[SF_U_BIT]                      = u;
    body[SF_C_BIT]                      = c;
    subframe                            = {even_parity(body[SF_C_BIT:4]), body};
  end

endmodule

// File: rtl/spdif_frame_sequencer.sv
// SPDIF transmit frame sequencer: pulls stereo pairs, builds left/right subframes,
// assigns B/M/W preambles and walks the 192-frame channel-status block.
module spdif_frame_sequencer
  import spdif_pkg::*;
#(
  parameter int SAMPLE_W = 24,
  parameter int CS_W     = 40
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [CS_W-1:0]     cs_bits,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] s_left,
  input  logic [SAMPLE_W-1:0] s_right,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [1:0]          m_preamble,
  output logic [31:0]         m_subframe,
  output logic [7:0]          frame_idx,
  output logic                block_start,
  output logic [15:0]         underrun_cnt,
  output logic                busy
);

  localparam int         CS_IDX_W = (CS_W > 1) ? $clog2(CS_W) : 1;
  localparam logic [7:0] CS_LIMIT = 8'(CS_W);

  seq_state_t          state, next_state;
  logic [SAMPLE_W-1:0] left_q, right_q;
  logic                v_q, c_q;
  logic [CS_W-1:0]     cs_shadow;
  logic [CS_W-1:0]     cs_word;
  logic                c_bit;
  logic [SAMPLE_W-1:0] cur_sample;
  logic [31:0]         packed_subframe;

  // State register; a synchronous reset aborts any frame in flight.
  // NOTE: sequential state is written with non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state decode and the handshake/strobe outputs derived from the state.
  always_comb begin
    next_state  = state;
    s_ready     = 1'b0;
    block_start = 1'b0;
    m_valid     = 1'b0;
    m_preamble  = PREAMBLE_B;
    case (state)
      ST_IDLE: begin
        if (enable) next_state = ST_LOAD;
      end
      ST_LOAD: begin
        s_ready     = s_valid;
        block_start = (frame_idx == 8'd0);
        next_state  = ST_LEFT;
      end
      ST_LEFT: begin
        m_valid    = 1'b1;
        m_preamble = (frame_idx == 8'd0) ? PREAMBLE_B : PREAMBLE_M;
        if (m_ready) next_state = ST_RIGHT;
      end
      ST_RIGHT: begin
        m_valid    = 1'b1;
        m_preamble = PREAMBLE_W;
        if (m_ready) next_state = enable ? ST_LOAD : ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Channel-status bit for the frame being loaded; frame 0 reads cs_bits directly
  // because the shadow is only refreshed on that same edge.
  always_comb begin
    cs_word = (frame_idx == 8'd0) ? cs_bits : cs_shadow;
    c_bit   = 1'b0;
    if (frame_idx < CS_LIMIT) c_bit = cs_word[frame_idx[CS_IDX_W-1:0]];
  end

  // Frame datapath: capture samples/flags in LOAD, advance the frame counter on RIGHT acceptance.
  // NOTE: the sample holding registers and the cs shadow are reset too, so nothing stale leaks out after rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      left_q       <= '0;
      right_q      <= '0;
      v_q          <= 1'b0;
      c_q          <= 1'b0;
      cs_shadow    <= '0;
      frame_idx    <= '0;
      underrun_cnt <= '0;
    end else begin
      if (state == ST_LOAD) begin
        left_q  <= s_valid ? s_left  : '0;
        right_q <= s_valid ? s_right : '0;
        v_q     <= ~s_valid;
        c_q     <= c_bit;
        if (!s_valid && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
        if (frame_idx == 8'd0) cs_shadow <= cs_bits;
      end
      if (state == ST_RIGHT && m_ready) begin
        if (!enable || frame_idx == LAST_FRAME) frame_idx <= '0;
        else                                    frame_idx <= frame_idx + 8'd1;
      end
    end
  end

  assign busy       = (state != ST_IDLE);
  assign cur_sample = (state == ST_RIGHT) ? right_q : left_q;
  assign m_subframe = m_valid ? packed_subframe : 32'd0;

  spdif_subframe_pack #(
    .SAMPLE_W (SAMPLE_W)
  ) u_pack (
    .sample   (cur_sample),
    .v        (v_q),
    .u        (1'b0),
    .c        (c_q),
    .subframe (packed_subframe)
  );

endmodule

// File: tb/tb_spdif_frame_sequencer.sv
// Self-checking bench for spdif_frame_sequencer: randomized frames compared against
// a frame-level reference model (frame counter, cs shadow, underrun count).
module tb_spdif_frame_sequencer;
  import spdif_pkg::*;

  localparam int SAMPLE_W = 24;
  localparam int CS_W     = 40;

  logic                clk = 1'b0;
  logic                rst;
  logic                enable;
  logic [CS_W-1:0]     cs_bits;
  logic                s_valid;
  logic                s_ready;
  logic [SAMPLE_W-1:0] s_left;
  logic [SAMPLE_W-1:0] s_right;
  logic                m_valid;
  logic                m_ready;
  logic [1:0]          m_preamble;
  logic [31:0]         m_subframe;
  logic [7:0]          frame_idx;
  logic                block_start;
  logic [15:0]         underrun_cnt;
  logic                busy;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int              m_frame;
  int              m_underruns;
  logic [CS_W-1:0] m_shadow;
  int              m_blocks;

  always #5 clk = ~clk;

  spdif_frame_sequencer #(
    .SAMPLE_W (SAMPLE_W),
    .CS_W     (CS_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .cs_bits      (cs_bits),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_left       (s_left),
    .s_right      (s_right),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_preamble   (m_preamble),
    .m_subframe   (m_subframe),
    .frame_idx    (frame_idx),
    .block_start  (block_start),
    .underrun_cnt (underrun_cnt),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Subframe as the standard describes it: fields placed by position, parity by counting ones.
  function automatic logic [31:0] model_subframe(input logic [23:0] smp, input bit v, input bit c);
    logic [31:0] w;
    int          ones;
    w    = {1'b0, c, 1'b0, v, smp, 4'b0000};
    ones = 0;
    for (int i = 4; i <= 30; i++) if (w[i]) ones++;
    w[31] = (ones % 2) == 1;
    return w;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_s_ready"},      64'(s_ready),      64'(0));
    check({tag, "_m_valid"},      64'(m_valid),      64'(0));
    check({tag, "_m_preamble"},   64'(m_preamble),   64'(0));
    check({tag, "_m_subframe"},   64'(m_subframe),   64'(0));
    check({tag, "_frame_idx"},    64'(frame_idx),    64'(0));
    check({tag, "_block_start"},  64'(block_start),  64'(0));
    check({tag, "_underrun_cnt"}, 64'(underrun_cnt), 64'(0));
    check({tag, "_busy"},         64'(busy),         64'(0));
  endtask

  // Present one subframe for 'stall' refused cycles (random if negative), then accept it.
  // Entered and left at a negedge.
  task automatic send_sub(input string tag, input logic [1:0] ep, input logic [31:0] es, input int stall);
    int waits;
    waits = (stall >= 0) ? stall : int'($urandom_range(0, 2));
    for (int i = 0; i <= waits; i++) begin
      check({tag, "_m_valid"},     64'(m_valid),     64'(1));
      check({tag, "_m_preamble"},  64'(m_preamble),  64'(ep));
      check({tag, "_m_subframe"},  64'(m_subframe),  64'(es));
      check({tag, "_frame_idx"},   64'(frame_idx),   64'(m_frame));
      check({tag, "_s_ready"},     64'(s_ready),     64'(0));
      check({tag, "_block_start"}, 64'(block_start), 64'(0));
      m_ready = (i == waits);
      @(negedge clk);
    end
    m_ready = 1'b0;
  endtask

  // One full frame, entered at the negedge where the DUT sits in LOAD.
  task automatic do_frame(input bit sv, input logic [23:0] l, input logic [23:0] r,
                          input int left_stall, input bit drop_en, input bit rst_in_right);
    logic [23:0] el, er;
    bit          ev, ec;
    logic [31:0] exp_l, exp_r;
    logic [1:0]  exp_pl;

    s_valid = sv;
    s_left  = l;
    s_right = r;
    m_ready = 1'b0;
    if (m_frame == 0) begin
      m_shadow = cs_bits;
      m_blocks++;
    end
    ev = !sv;
    el = sv ? l : 24'd0;
    er = sv ? r : 24'd0;
    ec = (m_frame < CS_W) ? m_shadow[m_frame] : 1'b0;
    if (!sv && m_underruns < 65535) m_underruns++;
    exp_l  = model_subframe(el, ev, ec);
    exp_r  = model_subframe(er, ev, ec);
    exp_pl = (m_frame == 0) ? PREAMBLE_B : PREAMBLE_M;

    #1;
    check("load_s_ready",     64'(s_ready),     64'(sv));
    check("load_block_start", 64'(block_start), 64'(m_frame == 0));
    check("load_m_valid",     64'(m_valid),     64'(0));
    check("load_busy",        64'(busy),        64'(1));
    @(negedge clk);

    // A fresh pair offered after LOAD must wait for the next LOAD; cs_bits may wander mid-block.
    s_valid = 1'b1;
    s_left  = 24'($urandom);
    s_right = 24'($urandom);
    if ($urandom_range(0, 7) == 0) cs_bits = {8'($urandom), $urandom};
    if (drop_en) enable = 1'b0;

    send_sub("left", exp_pl, exp_l, left_stall);

    if (rst_in_right) begin
      check("right_m_preamble", 64'(m_preamble), 64'(PREAMBLE_W));
      check("right_m_subframe", 64'(m_subframe), 64'(exp_r));
      rst     = 1'b1;
      enable  = 1'b0;
      @(negedge clk);
    end else begin
      send_sub("right", PREAMBLE_W, exp_r, -1);
      m_frame = drop_en ? 0 : (m_frame + 1) % FRAMES_PER_BLOCK;
      check("underrun_cnt", 64'(underrun_cnt), 64'(m_underruns));
      if (drop_en) begin
        check("stop_busy",      64'(busy),      64'(0));
        check("stop_m_valid",   64'(m_valid),   64'(0));
        check("stop_frame_idx", 64'(frame_idx), 64'(0));
      end
    end
  endtask

  initial begin
    bit          sv;
    logic [23:0] l, r;

    rst         = 1'b1;
    enable      = 1'b0;
    cs_bits     = '0;
    s_valid     = 1'b0;
    s_left      = '0;
    s_right     = '0;
    m_ready     = 1'b0;
    m_frame     = 0;
    m_underruns = 0;
    m_shadow    = '0;
    m_blocks    = 0;

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'(0));

    // Two full blocks plus two frames: all data valid except a 3-frame underrun, cs=5 at block starts.
    enable = 1'b1;
    @(negedge clk);
    for (int f = 0; f < 386; f++) begin
      sv = !(f >= 20 && f < 23);
      if (f == 0) begin
        l = 24'hABCDEF;
        r = 24'h123456;
      end else begin
        l = 24'($urandom);
        r = 24'($urandom);
      end
      if (m_frame == 0) cs_bits = (f < 384) ? 40'h00_0000_0005 : {8'($urandom), $urandom};
      do_frame(sv, l, r, (f == 7) ? 10 : -1, f == 385, 1'b0);
      if (f == 22) check("underrun_after_gap", 64'(underrun_cnt), 64'(3));
    end
    check("blocks_started", 64'(m_blocks), 64'(3));

    // Random data availability; stop after frame 5, restart, then reset mid-RIGHT.
    enable = 1'b1;
    @(negedge clk);
    for (int f = 0; f < 6; f++) begin
      do_frame($urandom_range(0, 3) != 0, 24'($urandom), 24'($urandom), -1, f == 5, 1'b0);
    end
    repeat (3) @(negedge clk);
    check("idle_frame_idx", 64'(frame_idx), 64'(0));
    check("idle_m_valid",   64'(m_valid),   64'(0));

    enable = 1'b1;
    @(negedge clk);
    for (int f = 0; f < 3; f++) begin
      do_frame(f != 1, 24'($urandom), 24'($urandom), -1, 1'b0, f == 2);
    end
    check_idle_outputs("rst_mid_right");
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", 64'(busy), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
